// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit_if : data-memory req/ready bus                     |
// | Rev 1.0  initial release                                           |
// +--------------------------------------------------------------------+
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit : MEM-stage load/store unit with req/ready handshake|
// | Optional misaligned trap: define MEM_MISALIGN_TRAP_EN               |
// | Rev 1.0  initial release                                           |
// +--------------------------------------------------------------------+
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_mem_memread,
  input  logic                     ex_mem_memwrite,
  input  logic [2:0]               ex_mem_funct3,
  input  logic [31:0]              ex_mem_addr,
  input  logic [31:0]              store_data,
  mem_access_unit_if.master        dmem,
  output logic [31:0]              read_data,
  output logic                     mem_stall,
  output logic                     bus_timeout,
  output logic                     misaligned_exc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic              access;
  logic              timeout_hit;
  logic [1:0]        size_q;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [3:0]        be_fmt;
  logic [31:0]       wdata_fmt;

  assign access      = ex_mem_memread | ex_mem_memwrite;
  assign size_q      = funct3_q[1:0];
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_in;

  always_comb begin
    misaligned_in = 1'b0;
    if (ex_mem_funct3[1:0] == 2'b01 && ex_mem_addr[0])
      misaligned_in = 1'b1;
    else if (ex_mem_funct3[1:0] == 2'b10 && ex_mem_addr[1:0] != 2'b00)
      misaligned_in = 1'b1;
  end
`endif

  // Misaligned halves/words are folded onto their natural boundary.
  always_comb begin
    off = 2'b00;
    case (size_q)
      2'b00:   off = addr_q[1:0];
      2'b01:   off = {addr_q[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    ld_byte = dmem.dmem_rdata[7:0];
    case (off)
      2'd0: ld_byte = dmem.dmem_rdata[7:0];
      2'd1: ld_byte = dmem.dmem_rdata[15:8];
      2'd2: ld_byte = dmem.dmem_rdata[23:16];
      2'd3: ld_byte = dmem.dmem_rdata[31:24];
      default: ld_byte = dmem.dmem_rdata[7:0];
    endcase
    ld_half = off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = wdata_q;
    case (size_q)
      2'b00: begin
        be_fmt    = 4'b0001 << off;
        wdata_fmt = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << {off[1], 1'b0};
        wdata_fmt = {2{wdata_q[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_nxt        = state;
    mem_stall        = 1'b0;
    dmem.dmem_req    = 1'b0;
    dmem.dmem_we     = 1'b0;
    dmem.dmem_addr   = 32'h0;
    dmem.dmem_be     = 4'h0;
    dmem.dmem_wdata  = 32'h0;
    case (state)
      S_IDLE: begin
        if (access) begin
          mem_stall = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          state_nxt = misaligned_in ? S_DONE : S_REQ;
`else
          state_nxt = S_REQ;
`endif
        end
      end
      S_REQ: begin
        mem_stall       = 1'b1;
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = we_q;
        dmem.dmem_addr  = {addr_q[31:2], 2'b00};
        dmem.dmem_be    = be_fmt;
        dmem.dmem_wdata = wdata_fmt;
        if (dmem.dmem_ready || timeout_hit)
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'b000;
      we_q        <= 1'b0;
      read_data   <= 32'h0;
      bus_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      bus_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (access) begin
            addr_q   <= ex_mem_addr;
            funct3_q <= ex_mem_funct3;
            wdata_q  <= store_data;
            we_q     <= ex_mem_memwrite;
          end
        end
        S_REQ: begin
          if (dmem.dmem_ready) begin
            wait_cnt <= '0;
            if (!we_q)
              read_data <= ld_ext;
          end else if (timeout_hit) begin
            wait_cnt    <= '0;
            bus_timeout <= 1'b1;
            if (!we_q)
              read_data <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)
      misaligned_exc <= 1'b0;
    else
      misaligned_exc <= (state == S_IDLE) && access && misaligned_in;
  end
`else
  assign misaligned_exc = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench                  |
// | Rev 1.0  initial release                                           |
// +--------------------------------------------------------------------+
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        ex_mem_memread;
  logic        ex_mem_memwrite;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_addr;
  logic [31:0] store_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        bus_timeout;
  logic        misaligned_exc;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rd;

  mem_access_unit_if dmem_bus ();

  mem_access_unit #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_mem_memread  (ex_mem_memread),
    .ex_mem_memwrite (ex_mem_memwrite),
    .ex_mem_funct3   (ex_mem_funct3),
    .ex_mem_addr     (ex_mem_addr),
    .store_data      (store_data),
    .dmem            (dmem_bus),
    .read_data       (read_data),
    .mem_stall       (mem_stall),
    .bus_timeout     (bus_timeout),
    .misaligned_exc  (misaligned_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Zero-wait access: IDLE cycle, one REQ cycle with ready, then DONE.
  task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input logic [3:0] ebe, input logic [31:0] eaddr,
                           input logic [31:0] ewd, input logic [31:0] erd);
    @(negedge clk);
    ex_mem_memread  = !wr;
    ex_mem_memwrite = wr;
    ex_mem_funct3   = f3;
    ex_mem_addr     = a;
    store_data      = sd;
    #1;
    check_eq({tag, "_stall_idle"}, 32'(mem_stall), 32'd1);
    @(negedge clk);
    ex_mem_memread      = 1'b0;
    ex_mem_memwrite     = 1'b0;
    dmem_bus.dmem_ready = 1'b1;
    dmem_bus.dmem_rdata = rd;
    #1;
    check_eq({tag, "_req"},   32'(dmem_bus.dmem_req), 32'd1);
    check_eq({tag, "_we"},    32'(dmem_bus.dmem_we), 32'(wr));
    check_eq({tag, "_addr"},  dmem_bus.dmem_addr, eaddr);
    check_eq({tag, "_be"},    32'(dmem_bus.dmem_be), 32'(ebe));
    if (wr) check_eq({tag, "_wdata"}, dmem_bus.dmem_wdata, ewd);
    check_eq({tag, "_stall_req"}, 32'(mem_stall), 32'd1);
    @(negedge clk);
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    #1;
    check_eq({tag, "_req_done"},   32'(dmem_bus.dmem_req), 32'd0);
    check_eq({tag, "_stall_done"}, 32'(mem_stall), 32'd0);
    check_eq({tag, "_rdata"},      read_data, erd);
    check_eq({tag, "_exc"},        32'(misaligned_exc), 32'd0);
    last_rd = erd;
  endtask

  initial begin
    int stall_cnt;
    int req_cnt;
    int to_cnt;
    reset               = 1'b1;
    ex_mem_memread      = 1'b0;
    ex_mem_memwrite     = 1'b0;
    ex_mem_funct3       = 3'b000;
    ex_mem_addr         = 32'h0;
    store_data          = 32'h0;
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    last_rd             = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_req",   32'(dmem_bus.dmem_req), 32'd0);
    check_eq("rst_we",    32'(dmem_bus.dmem_we), 32'd0);
    check_eq("rst_addr",  dmem_bus.dmem_addr, 32'h0);
    check_eq("rst_be",    32'(dmem_bus.dmem_be), 32'h0);
    check_eq("rst_wdata", dmem_bus.dmem_wdata, 32'h0);
    check_eq("rst_rdata", read_data, 32'h0);
    check_eq("rst_to",    32'(bus_timeout), 32'd0);
    check_eq("rst_exc",   32'(misaligned_exc), 32'd0);
    check_eq("rst_stall", 32'(mem_stall), 32'd0);

    do_access("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 4'b1000, 32'h0000_1000, 32'h0, 32'hFFFF_FF80);
    do_access("sh",  1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 4'b1100, 32'h0000_2000, 32'hABCD_ABCD, last_rd);
    do_access("lh",  1'b0, 3'b001, 32'h0000_7002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0000_7000, 32'h0, 32'hFFFF_8001);
    do_access("lhu", 1'b0, 3'b101, 32'h0000_7002, 32'h0, 32'h8001_0000, 4'b1100, 32'h0000_7000, 32'h0, 32'h0000_8001);
    do_access("sb",  1'b1, 3'b000, 32'h0000_8001, 32'h1234_56EF, 32'h0, 4'b0010, 32'h0000_8000, 32'hEFEF_EFEF, last_rd);
    do_access("sw",  1'b1, 3'b010, 32'h0000_9000, 32'hDEAD_BEEF, 32'h0, 4'b1111, 32'h0000_9000, 32'hDEAD_BEEF, last_rd);
    do_access("lbu", 1'b0, 3'b100, 32'h0000_A002, 32'h0, 32'h0077_0000, 4'b0100, 32'h0000_A000, 32'h0, 32'h0000_0077);

    // LW with ready delayed three REQ cycles
    stall_cnt = 0;
    @(negedge clk);
    ex_mem_memread = 1'b1;
    ex_mem_funct3  = 3'b010;
    ex_mem_addr    = 32'h0000_4008;
    #1;
    if (mem_stall) stall_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ex_mem_memread      = 1'b0;
      dmem_bus.dmem_ready = (i == 3);
      dmem_bus.dmem_rdata = 32'h1234_5678;
      #1;
      if (mem_stall) stall_cnt++;
      check_eq("lwd_req",  32'(dmem_bus.dmem_req), 32'd1);
      check_eq("lwd_addr", dmem_bus.dmem_addr, 32'h0000_4008);
    end
    @(negedge clk);
    dmem_bus.dmem_ready = 1'b0;
    #1;
    if (mem_stall) stall_cnt++;
    check_eq("lwd_stall_cycles", 32'(stall_cnt), 32'd5);
    check_eq("lwd_rdata", read_data, 32'h1234_5678);

    // Timeout: ready never asserted
    req_cnt = 0;
    to_cnt  = 0;
    @(negedge clk);
    ex_mem_memread = 1'b1;
    ex_mem_funct3  = 3'b010;
    ex_mem_addr    = 32'h0000_5000;
    #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ex_mem_memread = 1'b0;
      #1;
      if (dmem_bus.dmem_req) req_cnt++;
      if (bus_timeout) to_cnt++;
    end
    check_eq("to_req_cycles", 32'(req_cnt), 32'd16);
    check_eq("to_pulses",     32'(to_cnt), 32'd1);
    check_eq("to_rdata",      read_data, 32'h0);
    check_eq("to_stall_idle", 32'(mem_stall), 32'd0);

    // Reset asserted on the second REQ cycle
    @(negedge clk);
    ex_mem_memread = 1'b1;
    ex_mem_funct3  = 3'b100;
    ex_mem_addr    = 32'h0000_6001;
    @(negedge clk);
    ex_mem_memread = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rstreq_req_before", 32'(dmem_bus.dmem_req), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rstreq_req",   32'(dmem_bus.dmem_req), 32'd0);
    check_eq("rstreq_be",    32'(dmem_bus.dmem_be), 32'h0);
    check_eq("rstreq_addr",  dmem_bus.dmem_addr, 32'h0);
    check_eq("rstreq_rdata", read_data, 32'h0);
    check_eq("rstreq_stall", 32'(mem_stall), 32'd0);
    do_access("lbu_after_rst", 1'b0, 3'b100, 32'h0000_6001, 32'h0, 32'h0000_9A00, 4'b0010, 32'h0000_6000, 32'h0, 32'h0000_009A);

`ifdef MEM_MISALIGN_TRAP_EN
    req_cnt = 0;
    to_cnt  = 0;
    @(negedge clk);
    ex_mem_memread = 1'b1;
    ex_mem_funct3  = 3'b010;
    ex_mem_addr    = 32'h0000_3001;
    #1;
    if (dmem_bus.dmem_req) req_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ex_mem_memread = 1'b0;
      #1;
      if (dmem_bus.dmem_req) req_cnt++;
      if (misaligned_exc) to_cnt++;
    end
    check_eq("mis_req_cycles", 32'(req_cnt), 32'd0);
    check_eq("mis_exc_pulses", 32'(to_cnt), 32'd1);
    check_eq("mis_rdata",      read_data, 32'h0000_009A);
`else
    do_access("lw_mis", 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 4'b1111, 32'h0000_3000, 32'h0, 32'hCAFE_F00D);
    do_access("sh_mis", 1'b1, 3'b001, 32'h0000_2003, 32'h0000_5A5A, 32'h0, 4'b1100, 32'h0000_2000, 32'h5A5A_5A5A, last_rd);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
